// File: rtl/mvm_result_serializer_if.sv
// Capture/stream bundle for mvm_result_serializer: ten parallel results in,
// one element per valid/ready transfer out.
interface mvm_result_serializer_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 24
);
    localparam int RW = 2 * IN_WIDTH + 4;

    logic                  in_ready;
    logic                  in_row_set;
    logic [9:0][RW-1:0]    e;
    logic                  space_avail;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  out_data;
    logic [3:0]            out_index;
    logic                  out_last;
    logic                  out_row_set;

    modport master (
        output in_ready, in_row_set, e, out_ready,
        input  space_avail, out_valid, out_data, out_index, out_last, out_row_set
    );

    modport slave (
        input  in_ready, in_row_set, e, out_ready,
        output space_avail, out_valid, out_data, out_index, out_last, out_row_set
    );
endinterface

// File: rtl/mvm_result_serializer.sv
// Double-buffered serializer for the 10-row MVM results. Optional feature
// macro MVM_SAT_OUT_EN: saturate instead of wrap when narrowing each element.
module mvm_result_serializer #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 24,
    parameter int SHIFT     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear_ovf,
    output logic                    overflow,
    mvm_result_serializer_if.slave  bus
);
    localparam int RW = 2 * IN_WIDTH + 4;

`ifdef MVM_SAT_OUT_EN
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`endif

    function automatic logic [OUT_WIDTH-1:0] narrow(input logic [RW-1:0] v);
        logic signed [RW-1:0] sh;
        sh = $signed(v) >>> SHIFT;
`ifdef MVM_SAT_OUT_EN
        if (sh > SAT_MAX) begin
            narrow = SAT_MAX[OUT_WIDTH-1:0];
        end else if (sh < SAT_MIN) begin
            narrow = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            narrow = sh[OUT_WIDTH-1:0];
        end
`else
        narrow = sh[OUT_WIDTH-1:0];
`endif
    endfunction

    logic [1:0][9:0][RW-1:0] bank_q, bank_d;
    logic [1:0]              row_set_q, row_set_d;
    logic [1:0]              count_q, count_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [3:0]              idx_q, idx_d;
    logic                    overflow_q, overflow_d;

    logic                    out_valid_s;
    logic                    last_s;
    logic                    cap_s;
    logic                    xfer_s;
    logic                    fin_s;
    logic                    acc_s;
    logic                    drop_s;

    // Next-state: capture into the write bank, advance the drain pointer, track occupancy.
    always_comb begin
        bank_d     = bank_q;
        row_set_d  = row_set_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        idx_d      = idx_q;

        out_valid_s = (count_q != 2'd0);
        last_s      = (idx_q == 4'd9);
        cap_s       = enable & bus.in_ready;
        xfer_s      = enable & out_valid_s & bus.out_ready;
        fin_s       = xfer_s & last_s;
        // A full buffer still takes a capture when its oldest bank frees on this edge.
        acc_s       = cap_s & ((count_q < 2'd2) | fin_s);
        drop_s      = cap_s & ~acc_s;

        if (acc_s) begin
            bank_d[wr_ptr_q]    = bus.e;
            row_set_d[wr_ptr_q] = bus.in_row_set;
            wr_ptr_d            = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (fin_s) begin
            idx_d    = 4'd0;
            rd_ptr_d = ~rd_ptr_q;
        end else if (xfer_s) begin
            idx_d = idx_q + 4'd1;
        end else begin
            idx_d = idx_q;
        end

        case ({acc_s, fin_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Set dominates a same-cycle clear so a drop is never lost.
        overflow_d = drop_s | (overflow_q & ~clear_ovf);
    end

    // Output decode; data is forced to zero whenever nothing is held.
    always_comb begin
        bus.out_valid   = out_valid_s;
        bus.out_index   = idx_q;
        bus.out_last    = out_valid_s & last_s;
        bus.space_avail = (count_q < 2'd2) | ((count_q == 2'd2) & out_valid_s & bus.out_ready & last_s);
        if (out_valid_s) begin
            bus.out_data    = narrow(bank_q[rd_ptr_q][idx_q]);
            bus.out_row_set = row_set_q[rd_ptr_q];
        end else begin
            bus.out_data    = {OUT_WIDTH{1'b0}};
            bus.out_row_set = 1'b0;
        end
        overflow = overflow_q;
    end

    // State registers; reset discards any buffered vectors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_q     <= '0;
            row_set_q  <= 2'b00;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            idx_q      <= 4'd0;
            overflow_q <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            row_set_q  <= row_set_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_mvm_result_serializer.sv
// Scoreboard bench for mvm_result_serializer: a driver feeds directed and random
// traffic and queues expected beats; a monitor checks every cycle's outputs.
module tb_mvm_result_serializer;
    localparam int IN_WIDTH  = 16;
    localparam int OUT_WIDTH = 24;
    localparam int SHIFT     = 8;
    localparam int RW        = 2 * IN_WIDTH + 4;

    typedef struct {
        longint data;
        int     idx;
        bit     last;
        bit     rs;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic clear_ovf;
    logic overflow;

    mvm_result_serializer_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

    mvm_result_serializer #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clear_ovf (clear_ovf),
        .overflow  (overflow),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    beat_t sb[$];
    bit    ovf_exp = 1'b0;
    bit    mon_en  = 1'b0;
    int    n_vec   = 0;
    int    n_err   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference narrowing: floor-divide by 2^SHIFT, then clamp or wrap into OUT_WIDTH signed.
    function automatic longint model_narrow(input logic [RW-1:0] raw);
        longint v, q, lim;
        v   = longint'($signed(raw));
        q   = v >>> SHIFT;
        lim = longint'(1) << (OUT_WIDTH - 1);
`ifdef MVM_SAT_OUT_EN
        if (q > lim - 1) return lim - 1;
        if (q < -lim) return -lim;
        return q;
`else
        q = q & ((lim << 1) - 1);
        if (q >= lim) q = q - (lim << 1);
        return q;
`endif
    endfunction

    // One clock of stimulus; the model decides acceptance from the pending-beat queue.
    task automatic step(input bit ir, input bit rs, input logic [9:0][RW-1:0] ev,
                        input bit ordy, input bit en, input bit clr);
        bit fin, acc, drop;
        @(negedge clk);
        #2;
        bus.in_ready   = ir;
        bus.in_row_set = rs;
        bus.e          = ev;
        bus.out_ready  = ordy;
        enable         = en;
        clear_ovf      = clr;
        fin  = en && ordy && (sb.size() > 0) && sb[0].last;
        acc  = en && ir && ((sb.size() <= 10) || fin);
        drop = en && ir && !acc;
        @(posedge clk);
        #1;
        if (acc) begin
            for (int k = 0; k < 10; k++) begin
                beat_t b;
                b.data = model_narrow(ev[k]);
                b.idx  = k;
                b.last = (k == 9);
                b.rs   = rs;
                sb.push_back(b);
            end
        end
        if (drop) ovf_exp = 1'b1;
        else if (clr) ovf_exp = 1'b0;
    endtask

    function automatic logic [9:0][RW-1:0] rand_vec();
        logic [9:0][RW-1:0] v;
        for (int k = 0; k < 10; k++) v[k] = RW'({$urandom, $urandom});
        return v;
    endfunction

    // Monitor: just before each rising edge, compare outputs to the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (mon_en) begin
                chk("out_valid", longint'(bus.out_valid), longint'(sb.size() > 0));
                chk("space_avail", longint'(bus.space_avail),
                    longint'((sb.size() <= 10) || (sb[0].last && bus.out_ready)));
                chk("overflow", longint'(overflow), longint'(ovf_exp));
                if (sb.size() > 0) begin
                    if (bus.out_valid) begin
                        chk("out_data", longint'($signed(bus.out_data)), sb[0].data);
                        chk("out_index", longint'(bus.out_index), longint'(sb[0].idx));
                        chk("out_last", longint'(bus.out_last), longint'(sb[0].last));
                        chk("out_row_set", longint'(bus.out_row_set), longint'(sb[0].rs));
                    end
                    if (enable && bus.out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic [9:0][RW-1:0] zv;
    logic [9:0][RW-1:0] v1;

    initial begin
        zv = '0;
        reset = 1'b0;
        enable = 1'b0;
        clear_ovf = 1'b0;
        bus.in_ready = 1'b0;
        bus.in_row_set = 1'b0;
        bus.e = '0;
        bus.out_ready = 1'b0;
        #3;
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_space_avail", longint'(bus.space_avail), 1);
        chk("rst_overflow", longint'(overflow), 0);
        chk("rst_out_data", longint'(bus.out_data), 0);
        chk("rst_out_index", longint'(bus.out_index), 0);
        chk("rst_out_last", longint'(bus.out_last), 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        mon_en = 1'b1;

        // Single vector, continuous drain: elements 1..10
        for (int k = 0; k < 10; k++) v1[k] = RW'(256 * (k + 1));
        step(1'b1, 1'b1, v1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b0, zv, 1'b1, 1'b1, 1'b0);

        // Three strobes back to back with a stalled sink: third one dropped
        step(1'b1, 1'b0, rand_vec(), 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, rand_vec(), 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, rand_vec(), 1'b0, 1'b1, 1'b0);
        #1;
        chk("t2_overflow", longint'(overflow), 1);
        chk("t2_space_avail", longint'(bus.space_avail), 0);
        step(1'b0, 1'b0, zv, 1'b0, 1'b1, 1'b1);
        #1;
        chk("t2_cleared", longint'(overflow), 0);

        // Capture coinciding with the final beat of a full buffer
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, zv, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, rand_vec(), 1'b1, 1'b1, 1'b0);
        #1;
        chk("t3_overflow", longint'(overflow), 0);
        chk("t3_index", longint'(bus.out_index), 0);
        chk("t3_row_set", longint'(bus.out_row_set), 1);
        for (int i = 0; i < 22; i++) step(1'b0, 1'b0, zv, 1'b1, 1'b1, 1'b0);

        // Narrowing boundaries
        v1 = rand_vec();
        v1[0] = RW'(-(longint'(1) << 30));
        v1[1] = {1'b0, {(RW-1){1'b1}}};
        v1[2] = {1'b1, {(RW-1){1'b0}}};
        v1[3] = RW'(longint'(1) << 30);
        step(1'b1, 1'b0, v1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, zv, 1'b1, 1'b1, 1'b0);
        #1;
        chk("t5_e3", longint'($signed(bus.out_data)), 4194304);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, zv, 1'b1, 1'b1, 1'b0);

        // Enable only every third cycle, random sink stalls
        for (int c = 0; c < 300; c++)
            step($urandom_range(0, 3) == 0, 1'($urandom), rand_vec(),
                 1'($urandom), (c % 3) == 0, 1'b0);
        // Mostly enabled, random clears
        for (int c = 0; c < 400; c++)
            step($urandom_range(0, 2) == 0, 1'($urandom), rand_vec(),
                 1'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, zv, 1'b1, 1'b1, 1'b0);

        // Async reset in the middle of a drain
        step(1'b1, 1'b0, rand_vec(), 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, rand_vec(), 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, rand_vec(), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, zv, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("t6_out_valid", longint'(bus.out_valid), 0);
        chk("t6_overflow", longint'(overflow), 0);
        chk("t6_space_avail", longint'(bus.space_avail), 1);
        chk("t6_out_index", longint'(bus.out_index), 0);
        sb.delete();
        ovf_exp = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        mon_en = 1'b1;
        step(1'b1, 1'b1, rand_vec(), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, zv, 1'b1, 1'b1, 1'b0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
